// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing the external SRAM among UART, decoder and VGA.
// Registered SRAM drive; read data returns tagged with the issuing port.
module sram_access_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Flush,
  input  logic [2:0]  req_i,
  input  logic [2:0]  we_n_i,
  input  logic [53:0] addr_i,
  input  logic [47:0] wdata_i,
  output logic [2:0]  gnt_o,
  output logic [2:0]  rvalid_o,
  output logic [15:0] rdata_o,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  function automatic logic [2:0] onehot(input logic [1:0] p);
    return 3'b001 << p;
  endfunction

  logic [17:0] addr [3];
  logic [15:0] wdata [3];

  for (genvar n = 0; n < 3; n++) begin : g_unpack
    assign addr[n]  = addr_i[18*n +: 18];
    assign wdata[n] = wdata_i[16*n +: 16];
  end

  logic [1:0] last_grant;
  logic [1:0] start;
  logic [1:0] cand;
  logic [1:0] sel;
  logic [3:0] burst_cnt;
  logic       hit;
  logic       keep;

  logic [READ_LATENCY-1:0] tag_v;
  logic [1:0]              tag_p [READ_LATENCY];

  // A burst only continues once started; a fresh reset lets port 0 win.
  assign keep = req_i[last_grant]
             && burst_cnt != 4'd0
             && burst_cnt < 4'(MAX_BURST);

  assign start = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;

  always_comb begin
    hit  = 1'b0;
    sel  = last_grant;
    cand = start;
    if (!Flush) begin
      if (keep) begin
        hit = 1'b1;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (!hit && req_i[cand]) begin
            hit = 1'b1;
            sel = cand;
          end
          cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
      end
    end
  end

  assign gnt_o = hit ? onehot(sel) : 3'b000;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      rdata_o         <= '0;
      rvalid_o        <= '0;
      last_grant      <= 2'd2;
      burst_cnt       <= '0;
      tag_v           <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_p[i] <= '0;
    end else if (Flush) begin
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      rdata_o         <= '0;
      rvalid_o        <= '0;
      last_grant      <= 2'd2;
      burst_cnt       <= '0;
      tag_v           <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_p[i] <= '0;
    end else begin
      tag_v[0] <= hit && we_n_i[sel];
      tag_p[0] <= sel;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
      end
      rvalid_o <= tag_v[READ_LATENCY-1] ?
                  onehot(tag_p[READ_LATENCY-1]) : 3'b000;
      if (tag_v[READ_LATENCY-1]) rdata_o <= SRAM_read_data;

      if (hit) begin
        SRAM_address    <= addr[sel];
        SRAM_write_data <= wdata[sel];
        SRAM_we_n       <= we_n_i[sel];
        last_grant      <= sel;
        if (sel != last_grant)       burst_cnt <= 4'd1;
        else if (burst_cnt != 4'hF)  burst_cnt <= burst_cnt + 4'd1;
      end else begin
        SRAM_we_n <= 1'b1;
        if (!req_i[last_grant]) burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a one-cycle SRAM model.
// Each task drives one scenario and compares against hand-derived values.
module tb_sram_access_arbiter;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Flush;
  logic [2:0]  req_i;
  logic [2:0]  we_n_i;
  logic [53:0] addr_i;
  logic [47:0] wdata_i;
  logic [2:0]  gnt_o;
  logic [2:0]  rvalid_o;
  logic [15:0] rdata_o;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;

  int vectors = 0;
  int miscompares = 0;

  sram_access_arbiter #(.READ_LATENCY(2), .MAX_BURST(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .Flush(Flush),
    .req_i(req_i), .we_n_i(we_n_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data)
  );

  always #10 Clock = ~Clock;

  // Unwritten locations read back as their own low 16 address bits.
  logic [15:0] mem [int];
  always @(posedge Clock) begin
    if (mem.exists(int'(SRAM_address)))
      SRAM_read_data <= mem[int'(SRAM_address)];
    else
      SRAM_read_data <= SRAM_address[15:0];
    if (!SRAM_we_n) mem[int'(SRAM_address)] = SRAM_write_data;
  end

  task automatic set_port(input int n, input logic [17:0] a,
                          input logic [15:0] d);
    addr_i[18*n +: 18]  = a;
    wdata_i[16*n +: 16] = d;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0; Flush = 1'b0;
    req_i = 3'b000; we_n_i = 3'b111;
    addr_i = '0; wdata_i = '0;
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    Resetn = 1'b1; Flush = 1'b0;
    req_i = 3'b000; we_n_i = 3'b111;
    addr_i = {3{18'h3ABCD}}; wdata_i = {3{16'hA5A5}};
    @(negedge Clock);
    Resetn = 1'b0;
    #3;
    vectors++;
    if (SRAM_address !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h want 0", SRAM_address);
    end
    vectors++;
    if (SRAM_write_data !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_wdata: got %h want 0", SRAM_write_data);
    end
    vectors++;
    if (SRAM_we_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_we_n: got %b want 1", SRAM_we_n);
    end
    vectors++;
    if (rvalid_o !== 3'b000 || rdata_o !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_rd: got %b/%h want 000/0000", rvalid_o, rdata_o);
    end
    vectors++;
    if (gnt_o !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_gnt_idle: got %b want 000", gnt_o);
    end
    req_i = 3'b111;
    #1;
    vectors++;
    if (gnt_o !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_first_winner: got %b want 001", gnt_o);
    end
    req_i = 3'b000;
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic test_uart_write();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      req_i = 3'b001; we_n_i = 3'b110;
      set_port(0, 18'(76800 + i), 16'(16'h1234 + i));
      #1;
      vectors++;
      if (gnt_o !== 3'b001) begin
        miscompares++;
        $display("FAIL wr_gnt[%0d]: got %b want 001", i, gnt_o);
      end
      @(posedge Clock); #1;
      vectors++;
      if (SRAM_address !== 18'(76800 + i) || SRAM_we_n !== 1'b0 ||
          SRAM_write_data !== 16'(16'h1234 + i)) begin
        miscompares++;
        $display("FAIL wr_drive[%0d]: got %0d/%b/%h want %0d/0/%h",
                 i, SRAM_address, SRAM_we_n, SRAM_write_data,
                 76800 + i, 16'h1234 + i);
      end
    end
    @(negedge Clock);
    req_i = 3'b000;
    @(posedge Clock); #1;
    vectors++;
    if (SRAM_we_n !== 1'b1 || SRAM_address !== 18'd76803) begin
      miscompares++;
      $display("FAIL wr_idle: got %b/%0d want 1/76803",
               SRAM_we_n, SRAM_address);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [6];
    logic [2:0] nxt;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    @(negedge Clock);
    we_n_i = 3'b111; req_i = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (gnt_o !== exp_g[c]) begin
        miscompares++;
        $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt_o, exp_g[c]);
      end
      // each requester pauses one cycle after being served
      nxt = ~exp_g[c];
      @(negedge Clock);
      req_i = nxt;
    end
    req_i = 3'b000;
  endtask

  task automatic test_lone_read();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      @(negedge Clock);
      we_n_i = 3'b111;
      if (c < 10) begin
        req_i = 3'b010;
        set_port(1, 18'(c), 16'h0);
      end else begin
        req_i = 3'b000;
      end
      #1;
      if (c < 10) begin
        vectors++;
        if (gnt_o !== 3'b010) begin
          miscompares++;
          $display("FAIL rd_gnt[%0d]: got %b want 010", c, gnt_o);
        end
      end
      @(posedge Clock); #1;
      vectors++;
      if (c >= 2 && c < 12) begin
        if (rvalid_o !== 3'b010 || rdata_o !== 16'(c - 2)) begin
          miscompares++;
          $display("FAIL rd_ret[%0d]: got %b/%h want 010/%h",
                   c, rvalid_o, rdata_o, 16'(c - 2));
        end
      end else if (rvalid_o !== 3'b000) begin
        miscompares++;
        $display("FAIL rd_quiet[%0d]: got %b want 000", c, rvalid_o);
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [2:0] exp_g [6];
    logic       p0_done;
    exp_g = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100};
    p0_done = 1'b0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock);
      we_n_i = 3'b111;
      req_i = {1'b1, 1'b0, (c >= 3) && !p0_done};
      #1;
      vectors++;
      if (gnt_o !== exp_g[c]) begin
        miscompares++;
        $display("FAIL burst_gnt[%0d]: got %b want %b", c, gnt_o, exp_g[c]);
      end
      if (gnt_o[0]) p0_done = 1'b1;
    end
    @(negedge Clock);
    req_i = 3'b000;
  endtask

  task automatic test_mixed();
    do_reset();
    @(negedge Clock);
    req_i = 3'b011; we_n_i = 3'b110;
    set_port(0, 18'h00100, 16'hBEEF);
    set_port(1, 18'h00100, 16'h0000);
    #1;
    vectors++;
    if (gnt_o !== 3'b001) begin
      miscompares++;
      $display("FAIL mix_wr_gnt: got %b want 001", gnt_o);
    end
    @(posedge Clock); #1;
    vectors++;
    if (SRAM_we_n !== 1'b0) begin
      miscompares++;
      $display("FAIL mix_wr_we_n: got %b want 0", SRAM_we_n);
    end
    @(negedge Clock);
    req_i = 3'b010;
    #1;
    vectors++;
    if (gnt_o !== 3'b010) begin
      miscompares++;
      $display("FAIL mix_rd_gnt: got %b want 010", gnt_o);
    end
    @(posedge Clock); #1;
    vectors++;
    if (SRAM_we_n !== 1'b1 || SRAM_address !== 18'h00100) begin
      miscompares++;
      $display("FAIL mix_rd_drive: got %b/%h want 1/00100",
               SRAM_we_n, SRAM_address);
    end
    @(negedge Clock);
    req_i = 3'b000;
    @(posedge Clock); #1;
    vectors++;
    if (rvalid_o !== 3'b000) begin
      miscompares++;
      $display("FAIL mix_no_wr_tag: got %b want 000", rvalid_o);
    end
    @(posedge Clock); #1;
    vectors++;
    if (rvalid_o !== 3'b010 || rdata_o !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL mix_ret: got %b/%h want 010/beef", rvalid_o, rdata_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge Clock);
      req_i = 3'b010; we_n_i = 3'b111;
      set_port(1, 18'(5 + c), 16'h0);
      @(posedge Clock);
    end
    @(negedge Clock);
    req_i = 3'b111; Flush = 1'b1;
    #1;
    vectors++;
    if (gnt_o !== 3'b000) begin
      miscompares++;
      $display("FAIL flush_gnt: got %b want 000", gnt_o);
    end
    @(posedge Clock); #1;
    vectors++;
    if (rvalid_o !== 3'b000 || SRAM_we_n !== 1'b1 ||
        SRAM_address !== 18'd0) begin
      miscompares++;
      $display("FAIL flush_state: got %b/%b/%h want 000/1/00000",
               rvalid_o, SRAM_we_n, SRAM_address);
    end
    @(negedge Clock);
    Flush = 1'b0;
    #1;
    vectors++;
    if (gnt_o !== 3'b001) begin
      miscompares++;
      $display("FAIL flush_next_gnt: got %b want 001", gnt_o);
    end
    @(negedge Clock);
    req_i = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock); #1;
      vectors++;
      if (rvalid_o === 3'b010) begin
        miscompares++;
        $display("FAIL flush_drop[%0d]: got %b want no port-1 return",
                 c, rvalid_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_uart_write();
    test_round_robin();
    test_lone_read();
    test_burst_cap();
    test_mixed();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
